auto_presser: RTL and testbench

Automated button-press generator that drives the reflex game's button inputs from its mismatch lights. It is the press-issuing end of the game's button and light interface. Each cycle it watches the 8-bit mismatch mask (code XOR toggled buttons), then emits clean, debounce-friendly press pulses on the mismatched buttons until the mask reads zero. It serves as a self-test and demo driver, muxed onto the game's button bus ahead of the player logic.

---
 rtl/auto_presser_if.sv | 34 +++
 rtl/auto_presser.sv | 159 +++++++++++++++
 tb/tb_auto_presser.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/auto_presser_if.sv
// -----------------------------------------------------------------------------
// auto_presser_if
// Button/light bus between the auto-presser and whatever drives and observes it.
//   start       : one-cycle request to begin solving
//   abort       : synchronous cancel back to IDLE
//   lights[7:0] : mismatch mask from the player (1 = button still needs a toggle)
//   presses[7:0]: registered button drive from the auto-presser
//   busy        : solver active (SCAN/PRESS/RELEASE/SETTLE)
//   done        : all lights cleared
//   error       : a pressed button did not clear its light
//   press_count : verified press events, saturating at 15
// master = the side issuing start/abort and providing lights (game / bench)
// slave  = the auto-presser itself
// -----------------------------------------------------------------------------
interface auto_presser_if;
   logic       start;
   logic       abort;
   logic [7:0] lights;
   logic [7:0] presses;
   logic       busy;
   logic       done;
   logic       error;
   logic [3:0] press_count;

   modport master (
      output start, abort, lights,
      input  presses, busy, done, error, press_count
   );

   modport slave (
      input  start, abort, lights,
      output presses, busy, done, error, press_count
   );
endinterface

// File: rtl/auto_presser.sv
// -----------------------------------------------------------------------------
// auto_presser
// Drives the reflex game's buttons from its mismatch lights until the mask is
// clear. Each press event is held HOLD_CYCLES, followed by GAP_CYCLES of release
// and SETTLE_CYCLES of waiting for the player's debounce and lights register,
// after which the targeted lights are checked.
//
// Ports:
//   clock       : rising-edge clock
//   reset       : synchronous, active-high
//   bus (slave) : start/abort/lights in; presses/busy/done/error/press_count out
//
// Build option:
//   AUTO_PRESSER_MULTI_EN : when defined, each event presses the whole mismatch
//                           mask at once; otherwise one button per event,
//                           lowest index first.
// -----------------------------------------------------------------------------
module auto_presser #(
   parameter int HOLD_CYCLES   = 6,
   parameter int GAP_CYCLES    = 3,
   parameter int SETTLE_CYCLES = 2
) (
   input  logic          clock,
   input  logic          reset,
   auto_presser_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE,
      SCAN,
      PRESS,
      RELEASE,
      SETTLE,
      DONE,
      ERROR
   } state_t;

   state_t     state_q,   state_d;
   logic [7:0] cnt_q,     cnt_d;
   logic [7:0] target_q,  target_d;
   logic [7:0] presses_q, presses_d;
   logic       busy_q,    busy_d;
   logic       done_q,    done_d;
   logic       error_q,   error_d;
   logic [3:0] count_q,   count_d;

   // Isolates the lowest set bit of the mask (two's-complement trick).
   logic [7:0] low_bit;
   assign low_bit = bus.lights & (~bus.lights + 8'd1);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      target_d  = target_q;
      presses_d = presses_q;
      done_d    = done_q;
      error_d   = error_q;
      count_d   = count_q;

      if (bus.abort) begin
         // abort wins over start; press_count is deliberately kept
         state_d   = IDLE;
         presses_d = 8'd0;
         done_d    = 1'b0;
         error_d   = 1'b0;
      end else begin
         unique case (state_q)
            IDLE, DONE, ERROR: begin
               if (bus.start) begin
                  state_d = SCAN;
                  count_d = 4'd0;
                  done_d  = 1'b0;
                  error_d = 1'b0;
               end
            end
            SCAN: begin
               if (bus.lights == 8'd0) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end else begin
`ifdef AUTO_PRESSER_MULTI_EN
                  target_d = bus.lights;
`else
                  target_d = low_bit;
`endif
                  presses_d = target_d;
                  cnt_d     = 8'(HOLD_CYCLES);
                  state_d   = PRESS;
               end
            end
            PRESS: begin
               if (cnt_q == 8'd1) begin
                  presses_d = 8'd0;
                  cnt_d     = 8'(GAP_CYCLES);
                  state_d   = RELEASE;
               end else begin
                  cnt_d = cnt_q - 8'd1;
               end
            end
            RELEASE: begin
               if (cnt_q == 8'd1) begin
                  cnt_d   = 8'(SETTLE_CYCLES);
                  state_d = SETTLE;
               end else begin
                  cnt_d = cnt_q - 8'd1;
               end
            end
            SETTLE: begin
               if (cnt_q == 8'd1) begin
                  // only the targeted bits are judged; others may move freely
                  if ((bus.lights & target_q) == 8'd0) begin
                     if (count_q != 4'd15) count_d = count_q + 4'd1;
                     state_d = SCAN;
                  end else begin
                     state_d = ERROR;
                     error_d = 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q - 8'd1;
               end
            end
            default: state_d = IDLE;
         endcase
      end

      // busy is registered from the next state so it tracks state_q exactly
      busy_d = (state_d == SCAN) || (state_d == PRESS) ||
               (state_d == RELEASE) || (state_d == SETTLE);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= 8'd0;
         presses_q <= 8'd0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
         count_q   <= 4'd0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         presses_q <= presses_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         error_q   <= error_d;
         count_q   <= count_d;
      end
      // target is pure data, only meaningful after a SCAN loads it
      target_q <= target_d;
   end

   assign bus.presses     = presses_q;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.error       = error_q;
   assign bus.press_count = count_q;

endmodule

// File: tb/tb_auto_presser.sv
// -----------------------------------------------------------------------------
// tb_auto_presser
// Drives auto_presser with directed and random mismatch masks through a simple
// player model (a press clears its lights unless that button is "ignored") and
// compares every output each cycle against a timeline computed from the
// press/release/settle rules. Honours AUTO_PRESSER_MULTI_EN like the design.
// -----------------------------------------------------------------------------
module tb_auto_presser;

   localparam int PERIOD = 12; // HOLD + GAP + SETTLE + SCAN with defaults
   localparam int HOLD   = 6;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   auto_presser_if bus ();

   auto_presser dut (
      .clock (clk),
      .reset (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int c, input logic [31:0] obs,
                        input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s @offset %0d: got 0x%0h expected 0x%0h", tag, c, obs, exp);
      end
   endtask

   // One solve attempt: start pulse, then per-cycle comparison against the model.
   // mid_start/abort_at: offsets (after the start edge) at which to raise start
   // or abort for one edge, or -1 for none.
   task automatic run(input logic [7:0] mask, input logic [7:0] ign,
                      input int mid_start, input int abort_at);
      logic [7:0] ev[$];
      int         n, e, term, last, hold_cnt;
      logic [7:0] ep;
      logic       eb, ed, ee;
      int         ec;

      ev = {};
      e  = -1;
`ifdef AUTO_PRESSER_MULTI_EN
      if (mask != 8'd0) begin
         ev.push_back(mask);
         if ((mask & ign) != 8'd0) e = 0;
      end
`else
      for (int b = 0; b < 8; b++) begin
         if (mask[b] && e < 0) begin
            ev.push_back(8'(1 << b));
            if (ign[b]) e = ev.size() - 1;
         end
      end
`endif
      n        = ev.size();
      term     = (e >= 0) ? PERIOD * (e + 1) : PERIOD * n + 1;
      last     = (abort_at >= 0) ? abort_at + 3 : term + 2;
      hold_cnt = 0;

      bus.lights = mask;
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;

      for (int c = 0; c <= last; c++) begin
         if (abort_at >= 0 && c > abort_at) begin
            ep = 8'd0; eb = 1'b0; ed = 1'b0; ee = 1'b0; ec = hold_cnt;
         end else if (c < term) begin
            eb = 1'b1; ed = 1'b0; ee = 1'b0;
            ec = c / PERIOD;
            if (ec > 15) ec = 15;
            ep = 8'd0;
            if (c >= 1 && (c - 1) / PERIOD < n && (c - 1) % PERIOD < HOLD)
               ep = ev[(c - 1) / PERIOD];
         end else begin
            ep = 8'd0; eb = 1'b0;
            ed = (e < 0);
            ee = (e >= 0);
            ec = (e >= 0) ? e : n;
         end
         if (c == abort_at) hold_cnt = ec;

         check("presses", c, 32'(bus.presses), 32'(ep));
         check("busy", c, 32'(bus.busy), 32'(eb));
         check("done", c, 32'(bus.done), 32'(ed));
         check("error", c, 32'(bus.error), 32'(ee));
         check("press_count", c, 32'(bus.press_count), 32'(ec));

         // player: a held button toggles its light unless that button is ignored
         if (bus.presses != 8'd0) bus.lights = bus.lights & ~(bus.presses & ~ign);
         bus.start = (c == mid_start);
         bus.abort = (c == abort_at);
         @(negedge clk);
      end
      bus.start = 1'b0;
      bus.abort = 1'b0;
   endtask

   initial begin
      logic [7:0] rm, ri;
      logic [3:0] held;
      total      = 0;
      bad        = 0;
      rst        = 1'b1;
      bus.start  = 1'b0;
      bus.abort  = 1'b0;
      bus.lights = 8'd0;
      repeat (3) @(negedge clk);
      check("rst_presses", 0, 32'(bus.presses), 32'd0);
      check("rst_busy", 0, 32'(bus.busy), 32'd0);
      check("rst_done", 0, 32'(bus.done), 32'd0);
      check("rst_error", 0, 32'(bus.error), 32'd0);
      check("rst_count", 0, 32'(bus.press_count), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // empty mask, two-bit mask, a button the player ignores
      run(8'h00, 8'h00, -1, -1);
      run(8'h05, 8'h00, -1, -1);
      run(8'h08, 8'h08, -1, -1);
      // start ignored mid-press; abort during the 3rd cycle of the second press
      run(8'h05, 8'h00, 3, -1);
      run(8'h05, 8'h00, -1, 15);
      run(8'hA3, 8'h00, -1, -1);

      // abort beats start in the same cycle; press_count must be held
      held = bus.press_count;
      bus.start = 1'b1;
      bus.abort = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      bus.abort = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("prio_busy", i, 32'(bus.busy), 32'd0);
         check("prio_done", i, 32'(bus.done), 32'd0);
         check("prio_count", i, 32'(bus.press_count), 32'(held));
         @(negedge clk);
      end

      for (int k = 0; k < 8; k++) begin
         rm = 8'($urandom);
         ri = ($urandom_range(0, 3) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
         run(rm, ri, -1, -1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
